// File: rtl/div_rr_scheduler_if.sv
// Request/response bundle for the shared round-robin divider.
interface div_rr_scheduler_if #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
);
  localparam int unsigned IW = $clog2(R);

  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_dd;
  logic [R*N-1:0] req_dr;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [N-1:0]   rsp_quo;
  logic [N-1:0]   rsp_rem;
  logic           rsp_dz;
  logic           busy;

  modport master (
    output req_valid, req_dd, req_dr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_dz, busy
  );

  modport slave (
    input  req_valid, req_dd, req_dr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_dz, busy
  );
endinterface

// File: rtl/div_rr_scheduler.sv
// One iterative non-restoring unsigned divider time-shared among R requesters
// through a round-robin arbiter; one operation in flight at a time.
module div_rr_scheduler #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
) (
  input  logic               clk,
  input  logic               rst,
  div_rr_scheduler_if.slave  bus
);
  localparam int unsigned IW = $clog2(R);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_q;
  logic [CW-1:0] cnt;
  logic [N:0]    acc;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic          dz_q;

  logic          rsp_valid_q;
  logic [IW-1:0] rsp_id_q;
  logic [N-1:0]  rsp_quo_q;
  logic [N-1:0]  rsp_rem_q;
  logic          rsp_dz_q;

  logic          found;
  logic [IW-1:0] win;
  logic [N-1:0]  dd_sel;
  logic [N-1:0]  dr_sel;
  logic [N:0]    acc_sh;
  logic [N:0]    acc_nx;
  logic [N-1:0]  q_nx;
  logic [N:0]    rem_fix;

  // Round-robin search: first valid index at or after ptr, wrapping at R.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < int'(R); k++) begin
      if (!found && bus.req_valid[(int'(ptr) + k) % int'(R)]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % int'(R));
      end
    end
  end

  assign dd_sel = bus.req_dd[int'(win) * int'(N) +: N];
  assign dr_sel = bus.req_dr[int'(win) * int'(N) +: N];

  assign bus.req_ready = (found && state == IDLE && !rst) ? (R'(1) << win) : '0;

  // One non-restoring step; N+1-bit wrap arithmetic stays exact since every
  // committed partial remainder lies in [-d, d).
  always_comb begin
    acc_sh  = {acc[N-1:0], q[N-1]};
    acc_nx  = acc[N] ? (acc_sh + {1'b0, d}) : (acc_sh - {1'b0, d});
    q_nx    = {q[N-2:0], ~acc_nx[N]};
    rem_fix = acc_nx[N] ? (acc_nx + {1'b0, d}) : acc_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      id_q        <= '0;
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      d           <= '0;
      dz_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_quo_q   <= '0;
      rsp_rem_q   <= '0;
      rsp_dz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id_q  <= win;
            ptr   <= (win == IW'(R - 1)) ? '0 : (win + IW'(1));
            acc   <= '0;
            q     <= dd_sel;
            d     <= dr_sel;
            dz_q  <= (dr_sel == '0);
            cnt   <= (dr_sel == '0) ? CW'(1) : CW'(N);
            state <= RUN;
          end
        end
        RUN: begin
          if (dz_q) begin
            // Divide by zero: skip the engine, report dividend as remainder.
            rsp_quo_q   <= '1;
            rsp_rem_q   <= q;
            rsp_dz_q    <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            acc <= acc_nx;
            q   <= q_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              rsp_quo_q   <= q_nx;
              rsp_rem_q   <= rem_fix[N-1:0];
              rsp_dz_q    <= 1'b0;
              rsp_id_q    <= id_q;
              rsp_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_dz_q    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_quo   = rsp_quo_q;
  assign bus.rsp_rem   = rsp_rem_q;
  assign bus.rsp_dz    = rsp_dz_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Scoreboard bench for div_rr_scheduler: a negedge monitor models arbitration,
// latency and results; directed and random tasks drive the requesters.
module tb_div_rr_scheduler;
  localparam int N = 8;
  localparam int R = 4;

  typedef struct {
    int id;
    int quo;
    int rem;
    int dz;
    int due;
  } exp_t;

  logic clk;
  logic rst;

  div_rr_scheduler_if #(.N(N), .R(R)) bus ();

  div_rr_scheduler #(.N(N), .R(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   grant_log[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   tb_ptr   = 0;
  int   n_grants = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: predicts req_ready/busy/rsp_valid each cycle, scores responses.
  always @(negedge clk) begin : monitor
    int            w;
    int            dd;
    int            dr;
    logic [R-1:0]  exp_rdy;
    logic          exp_rv;
    exp_t          e;
    if (rst) begin
      sb.delete();
      tb_ptr = 0;
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_busy", bus.busy, 0);
    end else begin
      w = -1;
      for (int k = 0; k < R; k++) begin
        if (w < 0 && bus.req_valid[(tb_ptr + k) % R]) w = (tb_ptr + k) % R;
      end
      exp_rdy = (sb.size() == 0 && w >= 0) ? (R'(1) << w) : '0;
      check("req_ready", bus.req_ready, exp_rdy);
      check("busy", bus.busy, sb.size() != 0);
      exp_rv = (sb.size() != 0) && (cyc >= sb[0].due);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      if (!exp_rv) check("rsp_dz_low", bus.rsp_dz, 0);
      if (exp_rv && bus.rsp_ready) begin
        e = sb.pop_front();
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_quo", bus.rsp_quo, e.quo);
        check("rsp_rem", bus.rsp_rem, e.rem);
        check("rsp_dz", bus.rsp_dz, e.dz);
      end
      if (exp_rdy != '0) begin
        dd = int'(bus.req_dd[w*N +: N]);
        dr = int'(bus.req_dr[w*N +: N]);
        e.id = w;
        if (dr == 0) begin
          e.quo = (1 << N) - 1;
          e.rem = dd;
          e.dz  = 1;
          e.due = cyc + 2;
        end else begin
          e.quo = dd / dr;
          e.rem = dd % dr;
          e.dz  = 0;
          e.due = cyc + 1 + N;
        end
        sb.push_back(e);
        grant_log.push_back(w);
        tb_ptr = (w + 1) % R;
        n_grants++;
      end
    end
  end

  task automatic await_grant(input int id, input int g0);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (n_grants > g0) begin ok = 1; break; end
    end
    #1 bus.req_valid[id] = 1'b0;
    check("accept_timeout", ok, 1);
  endtask

  task automatic issue(input int id, input int dd, input int dr);
    int g0 = n_grants;
    bus.req_dd[id*N +: N] = N'(dd);
    bus.req_dr[id*N +: N] = N'(dr);
    bus.req_valid[id]     = 1'b1;
    await_grant(id, g0);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    #1;
    check("idle_timeout", ok, 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    check("rst_quo", bus.rsp_quo, 0);
    check("rst_rem", bus.rsp_rem, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_dz", bus.rsp_dz, 0);
    check("rst_valid_now", bus.rsp_valid, 0);
    check("rst_busy_now", bus.busy, 0);
    check("rst_ready_now", bus.req_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [N-1:0] q0, r0;
    logic [1:0]   id0;
    logic         dz0;
    bit           ok;
    int           g0;
    int           exp_order[5];

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_dd    = '0;
    bus.req_dr    = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_dut();

    // Directed operand corners, including zero divisor.
    issue(2, 200, 7);   wait_idle();
    issue(0, 255, 255); wait_idle();
    issue(3, 5, 200);   wait_idle();
    issue(1, 128, 1);   wait_idle();
    issue(1, 9, 0);     wait_idle();

    for (int i = 0; i < 10; i++) begin
      issue($urandom_range(0, R-1), $urandom_range(0, 255),
            (i % 4 == 3) ? 0 : $urandom_range(1, 255));
      wait_idle();
    end

    // Consumer stall in DONE with a competing request pending.
    bus.rsp_ready = 1'b0;
    issue(3, 100, 9);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin ok = 1; break; end
    end
    check("stall_rsp_timeout", ok, 1);
    q0  = bus.rsp_quo;
    r0  = bus.rsp_rem;
    id0 = bus.rsp_id;
    dz0 = bus.rsp_dz;
    bus.req_dd[0 +: N] = N'(50);
    bus.req_dr[0 +: N] = N'(3);
    bus.req_valid[0]   = 1'b1;
    g0 = n_grants;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_quo", bus.rsp_quo, q0);
      check("stall_rem", bus.rsp_rem, r0);
      check("stall_id", bus.rsp_id, id0);
      check("stall_dz", bus.rsp_dz, dz0);
      check("stall_busy", bus.busy, 1);
      check("stall_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    await_grant(0, g0);
    wait_idle();

    // Round-robin fairness from a fresh reset with everyone requesting.
    reset_dut();
    for (int i = 0; i < R; i++) begin
      bus.req_dd[i*N +: N] = N'($urandom_range(0, 255));
      bus.req_dr[i*N +: N] = N'((i == 2) ? 0 : $urandom_range(1, 255));
    end
    grant_log.delete();
    g0 = n_grants;
    bus.req_valid = '1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (n_grants >= g0 + 5) begin ok = 1; break; end
    end
    #1 bus.req_valid = '0;
    check("rr_timeout", ok, 1);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
    end
    wait_idle();

    // Abort mid-run; nothing may come out for the aborted operation.
    issue(1, 77, 5);
    repeat (3) @(posedge clk);
    #1;
    reset_dut();
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_rsp", bus.rsp_valid, 0);
    issue(1, 77, 5);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_rr_scheduler.md
DIV_RR_SCHEDULER -- requirements
Module: div_rr_scheduler

Interface
REQ-001 Parameter N, default 8, operand/result width in bits (N >= 2).
REQ-002 Parameter R, default 4, number of requesters (R >= 2); IW = $clog2(R).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  R  per-requester request valid.
REQ-006 req_ready  output  R  per-requester accept strobe, at most one bit high.
REQ-007 req_dd  input  R*N  dividends; requester i uses bits [i*N +: N].
REQ-008 req_dr  input  R*N  divisors; requester i uses bits [i*N +: N].
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  IW  index of the requester owning the result.
REQ-012 rsp_quo  output  N  unsigned quotient.
REQ-013 rsp_rem  output  N  unsigned remainder.
REQ-014 rsp_dz  output  1  divide-by-zero flag.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Block SHALL time-share one internal iterative non-restoring divide engine among R requesters; one operation in flight at a time.
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 Arbitration: round-robin over req_valid starting at pointer ptr; winner = first asserted index at or after ptr, modulo R.
REQ-019 req_ready[i] SHALL be combinational: high only when state==IDLE, req_valid[i]==1 and i is the winner.
REQ-020 Acceptance = req_valid[i] & req_ready[i] at a rising edge; operands and id latched that edge; ptr <= (i+1) mod R.
REQ-021 Requesters SHALL hold valid and operands stable until accepted; block SHALL not sample unaccepted operands.
REQ-022 On acceptance with divisor != 0: IDLE -> RUN, iteration counter loaded with N.
REQ-023 RUN: exactly one non-restoring iteration per cycle (shift {acc,q} left, add or subtract divisor per sign of acc, quotient bit = NOT new sign); counter decrements.
REQ-024 Partial remainder SHALL be N+1 bits signed so results are exact for all unsigned operands, including MSB-set dividends and divisors.
REQ-025 On the final iteration edge: if acc negative, add divisor (restore); load rsp_quo, rsp_rem; RUN -> DONE.
REQ-026 Latency: rsp_valid rises exactly N clock edges after the acceptance edge.
REQ-027 Results SHALL satisfy dd == quo*dr + rem and rem < dr.
REQ-028 On acceptance with divisor == 0: IDLE -> DONE next edge, rsp_quo all ones, rsp_rem = dividend, rsp_dz=1; latency 1 edge.
REQ-029 rsp_dz SHALL be 0 for every nonzero divisor.
REQ-030 DONE: rsp_valid=1; rsp_id, rsp_quo, rsp_rem, rsp_dz held stable until rsp_valid & rsp_ready.
REQ-031 On response handshake: DONE -> IDLE; no request accepted in that same cycle (req_ready all zero outside IDLE).
REQ-032 rsp_valid, rsp_dz SHALL be 0 in IDLE and RUN; rsp_quo/rsp_rem keep last values.
REQ-033 req_valid changes during RUN/DONE SHALL not affect the in-flight operation.
REQ-034 No requester with continuous req_valid SHALL wait more than R-1 other grants.

Reset
REQ-035 rst high SHALL immediately force state IDLE, ptr 0, counter 0, rsp_valid 0, rsp_dz 0, rsp_id 0, rsp_quo 0, rsp_rem 0, busy 0, req_ready all 0 while asserted.
REQ-036 rst during RUN or DONE SHALL abort the operation; no response for it is ever produced.
REQ-037 First edge after rst release SHALL arbitrate from ptr 0.

Verification
REQ-038 N=8, R=4: only req 2 valid, dd=200, dr=7 -> accepted, rsp_valid N=8 edges later, id=2, quo=28, rem=4, dz=0.
REQ-039 dd=255, dr=255 -> quo=1, rem=0; dd=5, dr=200 -> quo=0, rem=5; dd=128, dr=1 -> quo=128, rem=0.
REQ-040 req 1 dd=9, dr=0 -> rsp_valid after 1 edge, quo=255, rem=9, dz=1.
REQ-041 All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; no back-to-back grant in the handshake cycle.
REQ-042 rsp_ready held low 10 cycles in DONE -> outputs stable, busy=1, no req_ready; then release -> single handshake, return to IDLE.
REQ-043 rst asserted 3 cycles into RUN -> all outputs reset at once, no response emitted; next request after release completes correctly.
